// File: rtl/comp_mac_engine_if.sv
// +----------------------------------------------------------------------+
// | comp_mac_engine_if : operand/result valid-ready bus of the MAC engine  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface comp_mac_engine_if #(
  parameter int DWIDTH   = 8,
  parameter int ACC_BITS = 4
);
  localparam int AWIDTH = 2*DWIDTH + 2 + ACC_BITS;

  logic                  op_val;
  logic                  op_rdy;
  logic [4*DWIDTH-1:0]   op_data;
  logic                  op_last;
  logic                  res_val;
  logic                  res_rdy;
  logic [2*AWIDTH-1:0]   res_data;

  modport master (
    output op_val, op_data, op_last, res_rdy,
    input  op_rdy, res_val, res_data
  );

  modport slave (
    input  op_val, op_data, op_last, res_rdy,
    output op_rdy, res_val, res_data
  );
endinterface

`default_nettype wire

// File: rtl/comp_mac_engine.sv
// +----------------------------------------------------------------------+
// | comp_mac_engine : complex multiply-accumulate over op_last frames     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module comp_mac_engine #(
  parameter int DWIDTH   = 8,
  parameter int NO_MULT  = 4,
  parameter int SIGNED   = 0,
  parameter int ACC_BITS = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          sw_rst,
  comp_mac_engine_if.slave   bus
);

  localparam int c_awidth = 2*DWIDTH + 2 + ACC_BITS;
  localparam int c_steps  = 4 / NO_MULT;
  localparam int c_sw     = (c_steps > 1) ? $clog2(c_steps) : 1;
  localparam logic [c_sw-1:0] c_last_step = c_sw'(c_steps - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_sw-1:0]       r_step;
  logic [DWIDTH-1:0]     r_x1, r_y1, r_x2, r_y2;
  logic                  r_last;
  logic [c_awidth-1:0]   r_acc_re, r_acc_im;
  logic                  r_res_val;
  logic [2*c_awidth-1:0] r_res_data;

  logic                  w_final;
  logic                  w_stall;
  logic                  w_do_step;
  logic                  w_op_rdy;
  logic                  w_accept;
  logic [c_awidth-1:0]   w_d_re, w_d_im;
  logic [c_awidth-1:0]   w_prod [NO_MULT];
  logic [1:0]            w_sel  [NO_MULT];

  // Multiplier m handles partial product index step*NO_MULT+m on each step.
  for (genvar m = 0; m < NO_MULT; m++) begin : g_mult
    logic [1:0]                 w_idx;
    logic [DWIDTH-1:0]          w_a, w_b;
    logic signed [DWIDTH:0]     w_ae, w_be;
    logic signed [2*DWIDTH+1:0] w_p;

    assign w_idx = 2'(int'(r_step) * NO_MULT + m);

    always_comb begin
      w_a = r_x1;
      w_b = r_x2;
      case (w_idx)
        2'd0:    begin w_a = r_x1; w_b = r_x2; end
        2'd1:    begin w_a = r_y1; w_b = r_y2; end
        2'd2:    begin w_a = r_x1; w_b = r_y2; end
        default: begin w_a = r_y1; w_b = r_x2; end
      endcase
    end

    assign w_ae = (SIGNED != 0) ? {w_a[DWIDTH-1], w_a} : {1'b0, w_a};
    assign w_be = (SIGNED != 0) ? {w_b[DWIDTH-1], w_b} : {1'b0, w_b};
    assign w_p  = w_ae * w_be;
    assign w_prod[m] = c_awidth'(w_p);
    assign w_sel[m]  = w_idx;
  end

  always_comb begin
    w_d_re = '0;
    w_d_im = '0;
    for (int m = 0; m < NO_MULT; m++) begin
      case (w_sel[m])
        2'd0:    w_d_re = w_d_re + w_prod[m];
        2'd1:    w_d_re = w_d_re - w_prod[m];
        default: w_d_im = w_d_im + w_prod[m];
      endcase
    end
  end

  // A last operand cannot finish while an unconsumed result sits in the output register.
  assign w_final   = (r_state != S_IDLE) && (r_step == c_last_step);
  assign w_stall   = w_final && r_last && r_res_val && !bus.res_rdy;
  assign w_do_step = (r_state != S_IDLE) && !w_stall;
  assign w_op_rdy  = !sw_rst && ((r_state == S_IDLE) ||
                                 ((r_state == S_CALC) && w_final && !w_stall));
  assign w_accept  = bus.op_val && w_op_rdy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_CALC;
      S_CALC: begin
        if (w_final) begin
          if (w_stall)       w_state_nxt = S_HOLD;
          else if (w_accept) w_state_nxt = S_CALC;
          else               w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: if (!w_stall) w_state_nxt = w_accept ? S_CALC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= S_IDLE;
    else if (sw_rst) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step     <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x2       <= '0;
      r_y2       <= '0;
      r_last     <= 1'b0;
      r_acc_re   <= '0;
      r_acc_im   <= '0;
      r_res_val  <= 1'b0;
      r_res_data <= '0;
    end else if (sw_rst) begin
      r_step     <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x2       <= '0;
      r_y2       <= '0;
      r_last     <= 1'b0;
      r_acc_re   <= '0;
      r_acc_im   <= '0;
      r_res_val  <= 1'b0;
      r_res_data <= '0;
    end else begin
      if (w_accept) begin
        r_x1   <= bus.op_data[4*DWIDTH-1:3*DWIDTH];
        r_y1   <= bus.op_data[3*DWIDTH-1:2*DWIDTH];
        r_x2   <= bus.op_data[2*DWIDTH-1:DWIDTH];
        r_y2   <= bus.op_data[DWIDTH-1:0];
        r_last <= bus.op_last;
      end

      if (w_accept || (w_do_step && w_final))
        r_step <= '0;
      else if (w_do_step)
        r_step <= r_step + 1'b1;

      if (w_do_step && w_final && r_last) begin
        r_res_data <= {r_acc_re + w_d_re, r_acc_im + w_d_im};
        r_acc_re   <= '0;
        r_acc_im   <= '0;
      end else if (w_do_step) begin
        r_acc_re <= r_acc_re + w_d_re;
        r_acc_im <= r_acc_im + w_d_im;
      end

      if (w_do_step && w_final && r_last)
        r_res_val <= 1'b1;
      else if (bus.res_rdy)
        r_res_val <= 1'b0;
    end
  end

  assign bus.op_rdy   = w_op_rdy;
  assign bus.res_val  = r_res_val;
  assign bus.res_data = r_res_data;

endmodule

`default_nettype wire

// File: tb/tb_comp_mac_engine.sv
// +----------------------------------------------------------------------+
// | tb_comp_mac_engine : directed checks on three engine configurations   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_comp_mac_engine;

  logic clk;
  logic rst_n;
  logic sw_rst;

  int n_tests = 0;
  int n_fail  = 0;

  comp_mac_engine_if #(.DWIDTH(8), .ACC_BITS(4)) a_if ();
  comp_mac_engine_if #(.DWIDTH(8), .ACC_BITS(4)) b_if ();
  comp_mac_engine_if #(.DWIDTH(8), .ACC_BITS(4)) c_if ();

  comp_mac_engine #(.DWIDTH(8), .NO_MULT(4), .SIGNED(0), .ACC_BITS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .bus(a_if));
  comp_mac_engine #(.DWIDTH(8), .NO_MULT(1), .SIGNED(0), .ACC_BITS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .bus(b_if));
  comp_mac_engine #(.DWIDTH(8), .NO_MULT(2), .SIGNED(1), .ACC_BITS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [43:0] rv(input int re, input int im);
    logic [21:0] r;
    logic [21:0] i;
    r = 22'(re);
    i = 22'(im);
    return {r, i};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    a_if.op_val = 1'b1; a_if.op_data = d; a_if.op_last = l;
    #1;
    while (!a_if.op_rdy && n < 20) begin @(negedge clk); n++; end
    check("a_accept_timeout", 64'(n < 20), 64'd1);
    @(negedge clk);
    a_if.op_val = 1'b0;
  endtask

  task automatic wait_a(input string tag, input logic [43:0] e);
    int n;
    n = 0;
    while (!a_if.res_val && n < 20) begin @(negedge clk); n++; end
    check(tag, 64'({a_if.res_val, a_if.res_data}), 64'({1'b1, e}));
  endtask

  task automatic send_c(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    c_if.op_val = 1'b1; c_if.op_data = d; c_if.op_last = l;
    #1;
    while (!c_if.op_rdy && n < 20) begin @(negedge clk); n++; end
    check("c_accept_timeout", 64'(n < 20), 64'd1);
    @(negedge clk);
    c_if.op_val = 1'b0;
  endtask

  task automatic wait_c(input string tag, input logic [43:0] e);
    int n;
    n = 0;
    while (!c_if.res_val && n < 20) begin @(negedge clk); n++; end
    check(tag, 64'({c_if.res_val, c_if.res_data}), 64'({1'b1, e}));
  endtask

  initial begin
    logic [7:0] rdy_pat;
    logic [7:0] val_pat;

    rst_n = 1'b0; sw_rst = 1'b0;
    a_if.op_val = 1'b0; a_if.op_data = '0; a_if.op_last = 1'b0; a_if.res_rdy = 1'b0;
    b_if.op_val = 1'b0; b_if.op_data = '0; b_if.op_last = 1'b0; b_if.res_rdy = 1'b0;
    c_if.op_val = 1'b0; c_if.op_data = '0; c_if.op_last = 1'b0; c_if.res_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a", 64'({a_if.res_val, a_if.res_data}), 64'd0);
    check("rst_b", 64'({b_if.res_val, b_if.res_data}), 64'd0);
    check("rst_c", 64'({c_if.res_val, c_if.res_data}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single operand, one-cycle latency
    a_if.res_rdy = 1'b1;
    send_a(32'h02030402, 1'b1);
    check("t1_not_yet", 64'(a_if.res_val), 64'd0);
    @(negedge clk);
    check("t1_res", 64'({a_if.res_val, a_if.res_data}), 64'({1'b1, rv(2, 16)}));
    @(negedge clk);
    check("t1_consumed", 64'(a_if.res_val), 64'd0);

    // Two-operand frame
    send_a(32'h02030402, 1'b0);
    send_a(32'h03030402, 1'b1);
    check("t2_no_early", 64'(a_if.res_val), 64'd0);
    @(negedge clk);
    check("t2_res", 64'({a_if.res_val, a_if.res_data}), 64'({1'b1, rv(8, 34)}));
    @(negedge clk);

    // Backpressure into HOLD
    a_if.res_rdy = 1'b0;
    a_if.op_val = 1'b1; a_if.op_data = 32'h01010101; a_if.op_last = 1'b1;
    @(negedge clk);
    a_if.op_data = 32'h02030402;
    @(negedge clk);
    check("hold_stall_rdy", 64'(a_if.op_rdy), 64'd0);
    check("hold_first", 64'({a_if.res_val, a_if.res_data}), 64'({1'b1, rv(0, 2)}));
    a_if.op_data = 32'h07070707; a_if.op_last = 1'b0;
    @(negedge clk);
    check("hold_rdy", 64'(a_if.op_rdy), 64'd0);
    check("hold_stable", 64'({a_if.res_val, a_if.res_data}), 64'({1'b1, rv(0, 2)}));
    a_if.op_val = 1'b0;
    a_if.res_rdy = 1'b1;
    @(negedge clk);
    check("hold_reload", 64'({a_if.res_val, a_if.res_data}), 64'({1'b1, rv(2, 16)}));
    @(negedge clk);
    check("hold_drain", 64'({a_if.res_val, a_if.op_rdy}), 64'b01);

    // Soft reset discards a partial frame
    send_a(32'h05050505, 1'b0);
    send_a(32'h06060606, 1'b0);
    sw_rst = 1'b1;
    #1;
    check("swrst_rdy0", 64'(a_if.op_rdy), 64'd0);
    @(negedge clk);
    check("swrst_hold", 64'({a_if.res_val, a_if.op_rdy}), 64'd0);
    sw_rst = 1'b0;
    #1;
    check("swrst_release", 64'(a_if.op_rdy), 64'd1);
    send_a(32'h01000100, 1'b1);
    wait_a("swrst_res", rv(1, 0));
    @(negedge clk);

    // NO_MULT=1 throughput and latency
    b_if.res_rdy = 1'b1;
    b_if.op_val = 1'b1; b_if.op_data = 32'hFFFFFFFF; b_if.op_last = 1'b1;
    #1;
    check("b_idle_rdy", 64'(b_if.op_rdy), 64'd1);
    rdy_pat = '0;
    val_pat = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rdy_pat[i-1] = b_if.op_rdy;
      val_pat[i-1] = b_if.res_val;
      if (i == 4) b_if.op_data = 32'h01020304;
      if (i == 5) begin
        check("b_res1", 64'({b_if.res_val, b_if.res_data}), 64'({1'b1, rv(0, 130050)}));
        b_if.op_val = 1'b0;
      end
    end
    check("b_rdy_pattern", 64'(rdy_pat), 64'h88);
    check("b_val_pattern", 64'(val_pat), 64'h10);
    @(negedge clk);
    check("b_res2", 64'({b_if.res_val, b_if.res_data}), 64'({1'b1, rv(-5, 10)}));

    // Signed operands, NO_MULT=2
    c_if.res_rdy = 1'b1;
    send_c(32'h80808080, 1'b1);
    wait_c("c_neg128", rv(0, 32768));
    @(negedge clk);
    send_c(32'hFF000500, 1'b1);
    wait_c("c_neg1", rv(-5, 0));
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/comp_mac_engine.md
# comp_mac_engine

Parametrised complex multiply-accumulate engine, the successor to the fixed single-product complex multiplier. It accepts operand pairs {x1,y1,x2,y2} over a valid/ready interface and accumulates (x1+i·y1)·(x2+i·y2) across a frame delimited by `op_last`. It emits one accumulated {re,im} result per frame over a valid/ready interface. Signedness and multiplier count (area/throughput trade-off) are set at elaboration.

## Interface
- `DWIDTH`, 8, operand component width
- `NO_MULT`, 4, physical multipliers: 1, 2 or 4; S = 4/NO_MULT cycles per operand
- `SIGNED`, 0, 1 = operands two's complement, 0 = unsigned; results always two's complement
- `ACC_BITS`, 4, accumulation guard bits; AWIDTH = 2·DWIDTH+2+ACC_BITS
- `clk`  in  1  system clock
- `rst_n`  in  1  reset rst_n, asynchronous, active-low; clock clk
- `sw_rst`  in  1  synchronous soft reset, active high
- `op_val`  in  1  operands valid
- `op_rdy`  out  1  operands ready
- `op_data`  in  4·DWIDTH  {x1,y1,x2,y2}, x1 in MSBs
- `op_last`  in  1  marks the last operand of a frame; qualified by op_val
- `res_val`  out  1  result valid
- `res_rdy`  in  1  result ready
- `res_data`  out  2·AWIDTH  {re,im}, re in MSBs

## Operation
- Partial products: P0=x1·x2 (+re), P1=y1·y2 (−re), P2=x1·y2 (+im), P3=y1·x2 (+im). Each is sign- or zero-extended per `SIGNED` to AWIDTH and added to or subtracted from acc_re/acc_im.
- Steps per operand: S = 4/NO_MULT. NO_MULT=4 applies P0..P3 in 1 step. NO_MULT=2 applies {P0,P1} then {P2,P3}. NO_MULT=1 applies P0, P1, P2, P3 in that order.
- Accumulation is modulo 2^AWIDTH. A frame of up to 2^ACC_BITS operands is exact; longer frames wrap silently.
- Operand register captures op_data/op_last on op_val&op_rdy.
- FSM states:
  - IDLE: op_rdy=1.
  - CALC: step counter runs 0..S−1.
  - HOLD: final step of a last-flagged operand while the output register is occupied (res_val & ~res_rdy).
- FSM transitions:
  - IDLE→CALC on accept.
  - CALC→CALC on the final step if a new operand is accepted on the same edge.
  - CALC→IDLE on the final step with no accept.
  - CALC→HOLD when the final step is blocked.
  - HOLD→CALC/IDLE once unblocked, with the same accept rule.
- op_rdy = (state==IDLE) | (state==CALC & step==S−1 & ~blocked). It is 0 in HOLD and during sw_rst.
- Final step of a last-flagged operand:
  - res_data ← acc + final partial(s); res_val←1.
  - acc_re/acc_im ← 0 on the same edge.
- Output register holds res_data stable while res_val & ~res_rdy. res_val clears on res_rdy unless reloaded on the same edge.
- Reset (rst_n low, or sw_rst high at an edge):
  - state IDLE, step 0, acc 0, operand register 0.
  - res_val 0, res_data 0; op_rdy 0 while sw_rst is high.
  - A partial frame is discarded; its ops do not contribute to later results.

## Timing
- Throughput: one operand per S cycles with op_val held high and no backpressure.
- An operand accepted at edge N has its steps at edges N+1..N+S.
- Result latency: res_val rises after edge N+S for a last operand accepted at edge N. This is 1 cycle for NO_MULT=4 and 4 cycles for NO_MULT=1.
- Simultaneous res_rdy and reload: the old result is consumed and the new one loaded on the same edge; res_val stays 1 and no bubble is required.
- The input is not blocked by output backpressure except in HOLD; non-last operands keep accumulating.
- op_data/op_last are ignored while op_val=0.

## Test plan
- NO_MULT=4, SIGNED=0, DWIDTH=8, single operand (2,3,4,2) with op_last -> res_data re=2, im=16; res_val one cycle after accept.
- Frame (2,3,4,2),(3,3,4,2) with last on the second operand -> single result re=8, im=34; no result after the first operand.
- NO_MULT=1, op_val held high, all op_last=1, res_rdy=1:
  - op_rdy high 1 cycle in 4.
  - each result appears 4 cycles after its accept.
  - (255,255,255,255) -> re=0, im=130050.
- SIGNED=1, (−128,−128,−128,−128) -> re=0, im=32768; (−1,0,5,0) -> re=−5, im=0 (sign extended to AWIDTH).
- res_rdy=0, two back-to-back single-operand frames:
  - first result stays stable.
  - engine enters HOLD; op_rdy=0.
  - res_rdy=1 for one cycle -> second result loads on the same edge, res_val stays 1.
- sw_rst pulsed after 2 non-last operands of a frame, then frame (1,0,1,0) last -> re=1, im=0; res_val=0 and op_rdy=0 during sw_rst.
